// File: rtl/rv32_pkg.sv
// Shared RV32 constants: datapath width, result-source
// encodings and load funct3 codes.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: picks the addressed byte/halfword
// from the raw memory word and sign- or zero-extends it.
module wb_load_align
    import rv32_pkg::*;
#(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic [XLEN-1:0] read_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = read_data[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? read_data[31:16]
                               : read_data[15:0];

    always_comb begin
        data = read_data;
        unique case (1'b1)
            funct3 == F3_LB:
                data = {{(XLEN-8){byte_v[7]}}, byte_v};
            funct3 == F3_LBU:
                data = {{(XLEN-8){1'b0}}, byte_v};
            funct3 == F3_LH:
                data = {{(XLEN-16){half_v[15]}}, half_v};
            funct3 == F3_LHU:
                data = {{(XLEN-16){1'b0}}, half_v};
            funct3 == F3_LW:
                data = read_data;
            default:
                data = read_data;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, integer register file with
// write-through decode reads, and retired-instruction counter.
module wb_regfile
    import rv32_pkg::*;
#(
    parameter int XLEN      = rv32_pkg::XLEN,
    parameter int NREGS     = 32,
    parameter int BYPASS    = 1,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_w,
    input  logic                 regwrite_w,
    input  logic [1:0]           result_src_w,
    input  logic [2:0]           load_funct3_w,
    input  logic [1:0]           addr_lo_w,
    input  logic [XLEN-1:0]      read_data_w,
    input  logic [XLEN-1:0]      alu_result_w,
    input  logic [4:0]           rd_w,
    input  logic [XLEN-1:0]      pc_plus4_w,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    output logic [XLEN-1:0]      rd1_d,
    output logic [XLEN-1:0]      rd2_d,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [INSTRET_W-1:0] instret
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] load_data;
    logic            hit1;
    logic            hit2;

    wb_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .read_data(read_data_w),
        .funct3   (load_funct3_w),
        .addr_lo  (addr_lo_w),
        .data     (load_data)
    );

    // Reserved encoding falls back to the ALU result.
    always_comb begin
        wb_data = alu_result_w;
        unique case (1'b1)
            result_src_w == RES_ALU: wb_data = alu_result_w;
            result_src_w == RES_MEM: wb_data = load_data;
            result_src_w == RES_PC4: wb_data = pc_plus4_w;
            default:                 wb_data = alu_result_w;
        endcase
    end

    assign wb_en = valid_w & regwrite_w & (rd_w != 5'd0);
    assign wb_rd = rd_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[rd_w] <= wb_data;
        end
    end

    assign hit1 = (BYPASS != 0) && wb_en && (rs1_d == rd_w);
    assign hit2 = (BYPASS != 0) && wb_en && (rs2_d == rd_w);

    assign rd1_d = (rs1_d == 5'd0) ? '0 :
                   hit1 ? wb_data : regs[rs1_d];
    assign rd2_d = (rs2_d == 5'd0) ? '0 :
                   hit2 ? wb_data : regs[rs2_d];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (valid_w) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing instance and a
// non-bypassing narrow-counter instance share one stimulus.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_w;
    logic        regwrite_w;
    logic [1:0]  result_src_w;
    logic [2:0]  load_funct3_w;
    logic [1:0]  addr_lo_w;
    logic [31:0] read_data_w;
    logic [31:0] alu_result_w;
    logic [4:0]  rd_w;
    logic [31:0] pc_plus4_w;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;

    logic [31:0] rd1_d, rd2_d, wb_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] instret;

    logic [31:0] rd1_nb, rd2_nb, wb_data_nb;
    logic        wb_en_nb;
    logic [4:0]  wb_rd_nb;
    logic [3:0]  instret_nb;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_w      (valid_w),
        .regwrite_w   (regwrite_w),
        .result_src_w (result_src_w),
        .load_funct3_w(load_funct3_w),
        .addr_lo_w    (addr_lo_w),
        .read_data_w  (read_data_w),
        .alu_result_w (alu_result_w),
        .rd_w         (rd_w),
        .pc_plus4_w   (pc_plus4_w),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd1_d        (rd1_d),
        .rd2_d        (rd2_d),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .instret      (instret)
    );

    wb_regfile #(
        .BYPASS   (0),
        .INSTRET_W(4)
    ) u_nb (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_w      (valid_w),
        .regwrite_w   (regwrite_w),
        .result_src_w (result_src_w),
        .load_funct3_w(load_funct3_w),
        .addr_lo_w    (addr_lo_w),
        .read_data_w  (read_data_w),
        .alu_result_w (alu_result_w),
        .rd_w         (rd_w),
        .pc_plus4_w   (pc_plus4_w),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd1_d        (rd1_nb),
        .rd2_d        (rd2_nb),
        .wb_en        (wb_en_nb),
        .wb_rd        (wb_rd_nb),
        .wb_data      (wb_data_nb),
        .instret      (instret_nb)
    );

    typedef enum int {
        K_RD1, K_RD2, K_WBEN, K_WBDATA, K_WBRD,
        K_RD1NB, K_RD2NB, K_CNT, K_CNTNB
    } kind_t;

    typedef struct {
        string       tag;
        kind_t       kind;
        logic [63:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [32];
    logic [63:0] cnt;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h",
                     tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input kind_t k);
        case (k)
            K_RD1:    return 64'(rd1_d);
            K_RD2:    return 64'(rd2_d);
            K_WBEN:   return 64'(wb_en);
            K_WBDATA: return 64'(wb_data);
            K_WBRD:   return 64'(wb_rd);
            K_RD1NB:  return 64'(rd1_nb);
            K_RD2NB:  return 64'(rd2_nb);
            K_CNT:    return instret;
            K_CNTNB:  return 64'(instret_nb);
            default:  return 'x;
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k,
                        input logic [63:0] e);
        exp_t it;
        it.tag  = tag;
        it.kind = k;
        it.exp  = e;
        sbq.push_back(it);
    endtask

    task automatic drain();
        exp_t it;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            check(it.tag, observe(it.kind), it.exp);
        end
    endtask

    function automatic logic [31:0] rd_exp(
        input logic [4:0] rs, input logic en,
        input logic [4:0] rd, input logic [31:0] w,
        input logic byp);
        if (rs == 5'd0) return 32'h0;
        if (byp && en && rs == rd) return w;
        return mdl[rs];
    endfunction

    task automatic cyc(
        input string       tag,
        input logic        v,
        input logic        w,
        input logic [1:0]  src,
        input logic [2:0]  f3,
        input logic [1:0]  alo,
        input logic [31:0] rdat,
        input logic [31:0] alu,
        input logic [31:0] pc4,
        input logic [4:0]  rd,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [31:0] wexp);
        logic en;
        @(negedge clk);
        valid_w       = v;
        regwrite_w    = w;
        result_src_w  = src;
        load_funct3_w = f3;
        addr_lo_w     = alo;
        read_data_w   = rdat;
        alu_result_w  = alu;
        pc_plus4_w    = pc4;
        rd_w          = rd;
        rs1_d         = r1;
        rs2_d         = r2;
        en = v && w && (rd != 5'd0);
        push({tag, ".en"}, K_WBEN, 64'(en));
        push({tag, ".rd"}, K_WBRD, 64'(rd));
        if (en) push({tag, ".wb"}, K_WBDATA, 64'(wexp));
        push({tag, ".rd1"}, K_RD1,
             64'(rd_exp(r1, en, rd, wexp, 1'b1)));
        push({tag, ".rd2"}, K_RD2,
             64'(rd_exp(r2, en, rd, wexp, 1'b1)));
        push({tag, ".rd1nb"}, K_RD1NB,
             64'(rd_exp(r1, en, rd, wexp, 1'b0)));
        push({tag, ".rd2nb"}, K_RD2NB,
             64'(rd_exp(r2, en, rd, wexp, 1'b0)));
        push({tag, ".cnt"}, K_CNT, cnt);
        push({tag, ".cntnb"}, K_CNTNB, 64'(cnt[3:0]));
        #2;
        drain();
        if (en) mdl[rd] = wexp;
        if (v) cnt++;
    endtask

    task automatic alu_wr(input string tag,
                          input logic [4:0] rd,
                          input logic [31:0] val,
                          input logic [4:0] r1,
                          input logic [4:0] r2);
        cyc(tag, 1'b1, 1'b1, 2'b00, 3'b010, 2'b00,
            32'h0, val, 32'h0, rd, r1, r2, val);
    endtask

    task automatic bub(input string tag,
                       input logic [4:0] r1,
                       input logic [4:0] r2);
        cyc(tag, 1'b0, 1'b1, 2'b00, 3'b000, 2'b00,
            $urandom, $urandom, $urandom, 5'd9,
            r1, r2, 32'h0);
    endtask

    task automatic ld(input string tag,
                      input logic [2:0] f3,
                      input logic [1:0] alo,
                      input logic [31:0] e);
        cyc(tag, 1'b1, 1'b1, 2'b01, f3, alo,
            32'h80FF7F01, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0, e);
        bub({tag, ".st"}, 5'd3, 5'd3);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        cnt           = 64'h0;
        reset_n       = 1'b0;
        valid_w       = 1'b0;
        regwrite_w    = 1'b0;
        result_src_w  = 2'b00;
        load_funct3_w = 3'b000;
        addr_lo_w     = 2'b00;
        read_data_w   = 32'h0;
        alu_result_w  = 32'h0;
        rd_w          = 5'd0;
        pc_plus4_w    = 32'h0;
        rs1_d         = 5'd0;
        rs2_d         = 5'd0;

        repeat (2) @(negedge clk);
        rs1_d = 5'd5;
        #2;
        check("rst.rd1", 64'(rd1_d), 64'h0);
        check("rst.cnt", instret, 64'h0);
        reset_n = 1'b1;

        alu_wr("w5", 5'd5, 32'h1234, 5'd0, 5'd0);
        bub("r5", 5'd5, 5'd5);

        #1 reset_n = 1'b0;
        #1;
        check("arst.rd1", 64'(rd1_d), 64'h0);
        check("arst.cnt", instret, 64'h0);
        check("arst.cntnb", 64'(instret_nb), 64'h0);
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        cnt = 64'h0;

        @(negedge clk);
        valid_w      = 1'b1;
        regwrite_w   = 1'b1;
        result_src_w = 2'b00;
        alu_result_w = 32'h5555;
        rd_w         = 5'd5;
        rs1_d        = 5'd6;
        @(negedge clk);
        valid_w = 1'b0;
        reset_n = 1'b1;
        bub("rstwr", 5'd5, 5'd6);

        ld("lb", 3'b000, 2'd3, 32'hFFFFFF80);
        ld("lbu", 3'b100, 2'd1, 32'h0000007F);
        ld("lh", 3'b001, 2'd2, 32'hFFFF80FF);
        ld("lhu", 3'b101, 2'd0, 32'h00007F01);
        ld("lhodd", 3'b001, 2'd3, 32'hFFFF80FF);
        ld("lw", 3'b010, 2'd1, 32'h80FF7F01);

        cyc("res11", 1'b1, 1'b1, 2'b11, 3'b000, 2'b00,
            32'h1, 32'hA5A5A5A5, 32'h2, 5'd4, 5'd4, 5'd0,
            32'hA5A5A5A5);

        alu_wr("x0", 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        bub("x0.nx", 5'd0, 5'd0);

        alu_wr("x7old", 5'd7, 32'h11111111, 5'd0, 5'd0);
        alu_wr("byp", 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
        bub("byp.nx", 5'd7, 5'd7);

        cyc("link", 1'b1, 1'b1, 2'b10, 3'b000, 2'b00,
            32'h0, 32'h0, 32'h00000108, 5'd1, 5'd0, 5'd1,
            32'h00000108);
        bub("link.nx", 5'd1, 5'd4);

        for (int i = 0; i < 3; i++) bub("bub", 5'd9, 5'd3);
        for (int i = 0; i < 2; i++) begin
            cyc("st", 1'b1, 1'b0, 2'b00, 3'b010, 2'b00,
                $urandom, $urandom, $urandom, 5'd7,
                5'd7, 5'd9, 32'h0);
        end
        bub("st.nx", 5'd7, 5'd9);

        for (int i = 0; i < 20; i++) begin
            cyc("wrap", 1'b1, 1'b0, 2'b00, 3'b000, 2'b00,
                $urandom, $urandom, $urandom, 5'(i),
                5'd3, 5'd1, 32'h0);
        end
        bub("wrap.nx", 5'd3, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file for the five-stage RV32IM pipeline.
- Consumes the registered MEM/WB bundle, aligns and extends load data, and selects the result (ALU, load, PC+4).
- Writes the result into the 32x32 integer register file and serves the two decode-stage read ports with same-cycle write-through bypass.
- Exports the write-back beat for the forwarding unit and maintains the retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count; x0 hardwired to zero
- BYPASS, 1, 1 = decode reads see a same-cycle write; 0 = reads return the stored value only
- INSTRET_W, 64, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- valid_w  in  1  WB-stage slot holds a real instruction (bubbles = 0)
- regwrite_w  in  1  instruction writes rd
- result_src_w  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- load_funct3_w  in  3  load funct3
- addr_lo_w  in  2  effective-address bits [1:0] of the load
- read_data_w  in  XLEN  raw memory word
- alu_result_w  in  XLEN  ALU/MUL/DIV result
- rd_w  in  5  destination register
- pc_plus4_w  in  XLEN  link value
- rs1_d, rs2_d  in  5  decode read addresses
- rd1_d, rd2_d  out  XLEN  decode read data (combinational)
- wb_en  out  1  valid_w & regwrite_w & (rd_w != 0)
- wb_rd  out  5  rd_w
- wb_data  out  XLEN  selected, extended result (combinational)
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous): all registers x1..x31 = 0; instret = 0. rd1_d/rd2_d then return 0 for any address, except that a same-cycle bypass still applies. No write occurs while reset_n is low, even on a clock edge.
- Load alignment (combinational):
  - LB (000): sign-extend the byte selected by addr_lo_w.
  - LBU (100): zero-extend the same byte.
  - LH (001): sign-extend halfword addr_lo_w[1] (0 = bits [15:0], 1 = bits [31:16]); addr_lo_w[0] is ignored.
  - LHU (101): zero-extend the same halfword.
  - LW (010) and all other codes: whole word; addr_lo_w is ignored.
- Result select: 00 ALU, 01 aligned load, 10 pc_plus4_w, 11 ALU (reserved, must not X-propagate).
- Write: on posedge clk, if wb_en, regs[rd_w] <= wb_data. Single write port; latency 1 cycle to storage.
- x0: never written; reads of address 0 return 0 unconditionally, including under bypass when rd_w = 0.
- Read: combinational on rs1_d/rs2_d.
  - BYPASS=1: if wb_en and rs == rd_w, return wb_data (write-before-read within the cycle).
  - BYPASS=0: always return stored contents.
- Both read ports may address the same register, or rd_w, simultaneously; both return identical values.
- instret: increments by 1 on posedge when valid_w (independent of regwrite_w); wraps from all-ones to 0 with no flag.
- wb_data, wb_rd and wb_en are driven regardless of valid_w; consumers qualify with wb_en.
- Bubbles (valid_w = 0) cause no write and no count, whatever the other inputs are.

Decomposition:
- Package rv32_pkg holds:
  - result_src encodings (RES_ALU, RES_MEM, RES_PC4)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - XLEN
- One sub-module, wb_load_align: purely combinational byte/halfword select plus sign/zero extend (read_data, funct3, addr_lo -> XLEN).
- Storage array, bypass, select and counter stay in wb_regfile.

Test Plan:
- Reset test: reset_n low mid-run after writing x5 = 0x1234 -> rd1_d(rs1=5) = 0 immediately (asynchronous) and instret = 0.
- Load extension: read_data = 0x80FF7F01 with valid, regwrite, result_src=01, rd=3.
  - LB addr_lo=3 -> x3 = 0xFFFFFF80
  - LBU addr_lo=1 -> x3 = 0x0000007F
  - LH addr_lo=2 -> x3 = 0xFFFF80FF
  - LHU addr_lo=0 -> x3 = 0x00007F01
- x0 protection: write 0xDEADBEEF to rd=0 with rs1_d=rs2_d=0 that cycle -> wb_en = 0, rd1_d = rd2_d = 0, and still 0 the following cycle.
- Bypass (BYPASS=1): write alu_result = 0xCAFEF00D to x7 with rs1_d = rs2_d = 7 in the same cycle -> both outputs 0xCAFEF00D that cycle and after. Repeat with BYPASS=0 -> old value that cycle, new value next cycle.
- Link and bubbles:
  - result_src=10, pc_plus4 = 0x00000108, rd=1 -> x1 = 0x108.
  - Three bubbles then two valid non-writing stores -> instret rises by exactly 2 and no register changes.
- Wrap: force instret to 0xFFFFFFFFFFFFFFFF, retire one instruction -> instret = 0.
